mmio_pcm_capture: RTL

- MMIO-slot sample capture core: the receiving end of a PCM stream (16-bit pcm, data_valid strobe) produced by the DDFS/audio sources.
- Buffers decimated samples in a synchronous FIFO that the MicroBlaze MCS drains over the MMIO bus.
- Provides fill-level status, a sticky overflow flag and a threshold interrupt so firmware can capture waveforms for inspection.

---
 rtl/mmio_pcm_capture.sv | 78 +++++++
 1 files changed

// File: rtl/mmio_pcm_capture.sv
// mmio_pcm_capture: decimating PCM sample FIFO with level/overflow status and threshold irq, drained over an MMIO slot
module mmio_pcm_capture #(
    parameter int ADDR_W = 6,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cs,
    input  logic          write,
    input  logic          read,
    input  logic [4:0]    addr,
    input  logic [31:0]   write_data,
    output logic [31:0]   read_data,
    input  logic [DW-1:0] pcm_in,
    input  logic          pcm_valid,
    output logic          irq
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] wp, rp;
    logic [ADDR_W:0]   count, count_nxt, thresh;
    logic [7:0]        decim, dc;
    logic              enable, overflow;
    logic              wr, ctrl_wr, clr, empty, full, valid_ev, capture, do_pop, do_push;
    logic [DW-1:0]     head;
    logic              unused_ok;

    assign wr        = cs & write;
    assign ctrl_wr   = wr & (addr[2:0] == 3'd2);
    assign clr       = ctrl_wr & write_data[1];
    assign empty     = count == '0;
    assign full      = count == (ADDR_W+1)'(DEPTH);
    assign valid_ev  = pcm_valid & enable;
    assign capture   = valid_ev & (dc == 8'd0);
    assign do_pop    = wr & (addr[2:0] == 3'd1) & ~empty & ~clr;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the capture
    assign do_push   = capture & (~full | do_pop) & ~clr;
    assign count_nxt = count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    assign head      = empty ? '0 : mem[rp];
    assign unused_ok = &{1'b0, read, addr[4:3], write_data};

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= pcm_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dc       <= 8'd0;
            enable   <= 1'b0;
            decim    <= 8'd0;
            thresh   <= '0;
            irq      <= 1'b0;
        end else begin
            wp       <= clr ? '0 : wp + ADDR_W'(do_push);
            rp       <= clr ? '0 : rp + ADDR_W'(do_pop);
            count    <= clr ? '0 : count_nxt;
            overflow <= clr ? 1'b0 : overflow | (capture & full & ~do_pop);
            dc       <= ctrl_wr ? 8'd0 : valid_ev ? (dc == 8'd0 ? decim : dc - 8'd1) : dc;
            if (ctrl_wr) begin
                enable <= write_data[0];
                decim  <= write_data[15:8];
            end
            if (wr & (addr[2:0] == 3'd3)) thresh <= write_data[ADDR_W:0];
            irq      <= (thresh != '0) & (count >= thresh);
        end
    end

    always_comb begin
        read_data = (addr[2:0] == 3'd0) ? {empty, full, overflow, 13'd0, 16'(head)} :
                    (addr[2:0] == 3'd2) ? {16'd0, decim, 7'd0, enable} :
                    (addr[2:0] == 3'd3) ? 32'(count) : 32'd0;
    end
endmodule
